pipe_skid_slice: RTL
====================

// Module: pipe_skid_slice
//
// PURPOSE
//   Backward-registered pipeline slice (2-entry skid buffer) on the pipeline
//   valid/ready interface. It breaks the combinational ready path:
//   up.ready is driven from local state only and never from dn.ready.
//   It pairs with the forward valid/data slice on long ready chains, e.g.
//   between decode stall logic and fetch. It is fully throughput-preserving.
//
// PARAMETERS
//   FLUSH_EN   1'b1   1: flush input empties the slice; 0: flush is ignored
//
// PORTS
//   clk        in   1     clock; all state updates on posedge
//   rst        in   1     synchronous reset, active-high
//   flush      in   1     synchronous drop of all buffered entries
//   up.valid   in   1     upstream offers up.data
//   up.ready   out  1     slice can accept; function of state and rst only
//   up.data    in   T     payload (type T set by the pipeline interface)
//   dn.valid   out  1     main entry valid
//   dn.ready   in   1     downstream accepts dn.data
//   dn.data    out  T     main entry payload, driven directly from a register
//   occupancy  out  2     entries held: 0, 1 or 2 (debug/verification)
//
// BEHAVIOUR
//   - Storage: main reg (drives dn.data) and skid reg; data regs are not reset.
//   - acc = up.valid & up.ready; emit = dn.valid & dn.ready.
//   - States EMPTY(occ 0), ONE(occ 1), TWO(occ 2):
//       EMPTY: acc -> ONE, main<=up.data.
//       ONE:   acc & !emit -> TWO, skid<=up.data
//              !acc & emit -> EMPTY
//              acc & emit  -> ONE, main<=up.data
//              neither     -> ONE, hold
//       TWO:   emit -> ONE, main<=skid; no acc is possible (up.ready=0)
//              !emit -> TWO, hold
//   - up.ready = !rst & (state != TWO). dn.valid = (state != EMPTY).
//   - No combinational path from dn.ready or up.valid to any output.
//   - Latency: a beat accepted in cycle N is presented on dn in cycle N+1.
//     Order is strictly FIFO; no beat is duplicated or dropped except on
//     flush or reset.
//   - Throughput: one beat/cycle sustained when dn.ready is held at 1.
//   - dn.valid/dn.data stay stable while dn.valid & !dn.ready.
//   - Reset: state<=EMPTY, so dn.valid=0 and occupancy=0 from the first edge
//     with rst=1. up.ready=0 while rst=1 and 1 in the first cycle after.
//     Reset mid-transfer drops all held beats.
//   - Flush (FLUSH_EN=1): state<=EMPTY at the edge. A same-cycle acc beat is
//     discarded, although up.ready was 1 and the transfer counts upstream.
//     The emit in that cycle still completes downstream. rst has priority
//     over flush.
//
// TESTING
//   1. Reset: rst=1 for 2 cycles -> dn.valid=0, up.ready=0, occupancy=0;
//      first cycle after rst -> up.ready=1.
//   2. Streaming: dn.ready=1, push 0x10..0x1F back-to-back -> dn shows
//      0x10..0x1F one cycle later, one per cycle, occupancy stays 1.
//   3. Backpressure: dn.ready=0, push A,B,C -> A and B accepted, up.ready=0
//      from the cycle after B, C held upstream, occupancy=2.
//      Then dn.ready=1 -> A, B, C emitted in order, none lost.
//   4. Ready-path isolation: with the slice in ONE, toggle dn.ready within a
//      cycle -> up.ready unchanged until the next edge (no comb path).
//   5. Flush with occ=2 and up.valid=1 in the same cycle -> next cycle
//      dn.valid=0, occupancy=0, the offered beat is absent downstream.
//   6. Random valid/ready at 50% each for 10k beats against a scoreboard ->
//      in-order and lossless, dn stable under stall, occupancy<=2.

Source files
------------

// File: rtl/pipe_skid_slice.sv
// Two-entry skid buffer on a valid/ready link. up_ready_o is driven from local
// state and rst_i only, so the downstream ready path is registered.
module pipe_skid_slice #(
    parameter bit          FLUSH_EN  = 1'b1,
    parameter int unsigned DataWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 up_valid_i,
    output logic                 up_ready_o,
    input  logic [DataWidth-1:0] up_data_i,
    output logic                 dn_valid_o,
    input  logic                 dn_ready_i,
    output logic [DataWidth-1:0] dn_data_o,
    output logic [1:0]           occupancy_o
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [DataWidth-1:0] main_q, skid_q;
    logic                 acc, emit, flush_act;
    logic                 load_main_up, load_main_skid, load_skid;

    assign acc       = up_valid_i & up_ready_o;
    assign emit      = dn_valid_o & dn_ready_i;
    assign flush_act = FLUSH_EN & flush_i;
    assign dn_data_o = main_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main_up   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            StEmpty: begin
                if (acc) begin
                    state_d      = StOne;
                    load_main_up = 1'b1;
                end
            end
            StOne: begin
                if (acc && !emit) begin
                    state_d   = StTwo;
                    load_skid = 1'b1;
                end else if (!acc && emit) begin
                    state_d = StEmpty;
                end else if (acc && emit) begin
                    load_main_up = 1'b1;
                end
            end
            StTwo: begin
                if (emit) begin
                    state_d        = StOne;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
        // A flush discards everything, including a beat accepted this cycle.
        if (flush_act) begin
            state_d = StEmpty;
        end
    end

    always_comb begin
        up_ready_o  = !rst_i && (state_q != StTwo);
        dn_valid_o  = (state_q != StEmpty);
        occupancy_o = state_q;
    end

    always_ff @(posedge clk_i) begin
        if (load_main_up) begin
            main_q <= up_data_i;
        end else if (load_main_skid) begin
            main_q <= skid_q;
        end
        if (load_skid) begin
            skid_q <= up_data_i;
        end
    end

endmodule
